// File: rtl/pulse_meas_pkg.sv
// pulse_meas_pkg: FSM states, saturation limits and the result record shared by the pulse measurement block.
package pulse_meas_pkg;
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    WAIT_LOW  = 5'b00010,
    WAIT_RISE = 5'b00100,
    HIGH      = 5'b01000,
    DONE      = 5'b10000
  } state_t;
  localparam int WIDTH_MAX = 2047;
  localparam int GAP_MAX = 2**28 - 1;
  typedef struct packed {
    logic [10:0] width;
    logic [27:0] gap;
    logic [10:0] idx;
    logic        sat;
  } res_t;
endpackage

// File: rtl/pulse_edge_find.sv
// pulse_edge_find: registers transition info for one 8-sample word (bit 0 earliest).
// Ports: word in; prev = last sample of the registered word; rise/fall flags,
// first rise/fall positions, fall_first (fall precedes rise), glitch (>2 transitions).
module pulse_edge_find (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] word,
  output logic       prev,
  output logic       rise,
  output logic       fall,
  output logic [2:0] rise_pos,
  output logic [2:0] fall_pos,
  output logic       fall_first,
  output logic       glitch
);
  logic [7:0] t, r, f;
  logic [2:0] rp_n, fp_n;
  always_comb begin
    t = word ^ {word[6:0], prev};
    r = t & word;
    f = t & ~word;
    rp_n = '0;
    fp_n = '0;
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) rp_n = 3'(i);
      if (f[i]) fp_n = 3'(i);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      rise_pos <= '0;
      fall_pos <= '0;
      fall_first <= 1'b0;
      glitch <= 1'b0;
    end else begin
      prev <= word[7];
      rise <= |r;
      fall <= |f;
      rise_pos <= rp_n;
      fall_pos <= fp_n;
      fall_first <= fp_n < rp_n;
      glitch <= $countones(t) > 2;
    end
endmodule

// File: rtl/pulse_meas.sv
// pulse_meas: measures width, gap and index of pulses in a deserialized 8-sample/cycle stream.
// Ports: sample_i word stream; start_i arms a run of pulse_num_i pulses with timeout_us_i idle limit;
// res_* valid/ready result port; busy_o, done_o status; timeout_o/overflow_o/glitch_o sticky flags.
module pulse_meas
  import pulse_meas_pkg::*;
#(
  parameter int CYC_PER_US = 125,
  parameter int TS_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sample_i,
  input  logic        start_i,
  input  logic [10:0] pulse_num_i,
  input  logic [15:0] timeout_us_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [10:0] res_width_o,
  output logic [27:0] res_gap_o,
  output logic [10:0] res_idx_o,
  output logic        res_sat_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        overflow_o,
  output logic        glitch_o
);
  localparam int CW = $clog2(CYC_PER_US);
  state_t state;
  logic prev, er, ef, ff, gl;
  logic [2:0] rp, fp;
  logic s1, s2, s3;
  logic [10:0] num_q, idx;
  logic [15:0] to_q, us;
  logic [CW-1:0] cyc;
  logic [TS_W-4:0] wc;
  logic [TS_W-1:0] rise_ts, fall_ts, rts, fts, wdiff, gdiff;
  logic [27:0] gap_q, gap_n;
  logic gsat_q, gsat_n, wsat, zero_gap, active, tick, expire, complete, emit, last, start_new;
  res_t res_q, res_n;
  pulse_edge_find u_edge (
    .clk(clk), .rst_n(rst_n), .word(sample_i), .prev(prev), .rise(er), .fall(ef),
    .rise_pos(rp), .fall_pos(fp), .fall_first(ff), .glitch(gl)
  );
  assign res_width_o = res_q.width;
  assign res_gap_o = res_q.gap;
  assign res_idx_o = res_q.idx;
  assign res_sat_o = res_q.sat;
  // A fall-then-rise word measures the new gap from this word's fall; the first pulse of a run has no gap.
  always_comb begin
    rts = {wc, rp};
    fts = {wc, fp};
    wdiff = fts - (state == HIGH ? rise_ts : rts);
    gdiff = rts - (ef && ff ? fts : fall_ts);
    wsat = wdiff > TS_W'(WIDTH_MAX);
    zero_gap = idx == '0 && state != HIGH;
    gsat_n = !zero_gap && gdiff > TS_W'(GAP_MAX);
    gap_n = zero_gap ? '0 : gsat_n ? 28'(GAP_MAX) : gdiff[27:0];
    active = state inside {WAIT_LOW, WAIT_RISE, HIGH};
    tick = cyc == CW'(CYC_PER_US - 1);
    expire = active && !ef && to_q != '0 && tick && us + 16'd1 == to_q;
    complete = (state == HIGH && ef) || (state == WAIT_RISE && er && ef);
    emit = complete && !gl;
    last = num_q != '0 && idx + 11'd1 == num_q;
    start_new = !gl && er && ((state == WAIT_RISE && !ef) || (state == WAIT_LOW && ef) ||
                              (state == HIGH && ef && ff && !last));
    res_n = '{width: wsat ? 11'(WIDTH_MAX) : wdiff[10:0],
              gap: state == HIGH ? gap_q : gap_n,
              idx: idx,
              sat: wsat || (state == HIGH ? gsat_q : gsat_n)};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      {s1, s2, s3} <= '0;
      num_q <= '0;
      to_q <= '0;
      idx <= '0;
      us <= '0;
      cyc <= '0;
      wc <= '0;
      rise_ts <= '0;
      fall_ts <= '0;
      gap_q <= '0;
      gsat_q <= 1'b0;
      res_q <= '0;
      res_valid_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      timeout_o <= 1'b0;
      overflow_o <= 1'b0;
      glitch_o <= 1'b0;
    end else begin
      s1 <= start_i;
      s2 <= s1;
      s3 <= s2;
      wc <= wc + (TS_W-3)'(1);
      done_o <= 1'b0;
      if (res_valid_o && res_ready_i) res_valid_o <= 1'b0;
      if (emit) begin
        idx <= idx + 11'd1;
        if (!res_valid_o || res_ready_i) begin
          res_q <= res_n;
          res_valid_o <= 1'b1;
        end else overflow_o <= 1'b1;
      end
      case (state)
        IDLE: if (s2 && !s3) begin
          state <= prev ? WAIT_LOW : WAIT_RISE;
          busy_o <= 1'b1;
          num_q <= pulse_num_i;
          to_q <= timeout_us_i;
          idx <= '0;
          us <= '0;
          cyc <= '0;
          rise_ts <= '0;
          fall_ts <= '0;
          gap_q <= '0;
          gsat_q <= 1'b0;
          timeout_o <= 1'b0;
          overflow_o <= 1'b0;
          glitch_o <= 1'b0;
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: begin
          cyc <= ef || tick ? '0 : cyc + CW'(1);
          us <= ef ? '0 : tick ? us + 16'd1 : us;
          if (ef) fall_ts <= fts;
          if (expire) begin
            timeout_o <= 1'b1;
            state <= DONE;
          end else if (gl) begin
            glitch_o <= 1'b1;
            state <= prev ? WAIT_LOW : WAIT_RISE;
          end else if (start_new) begin
            rise_ts <= rts;
            gap_q <= gap_n;
            gsat_q <= gsat_n;
            state <= HIGH;
          end else if (emit && last) state <= DONE;
          else if (emit || (state == WAIT_LOW && ef)) state <= WAIT_RISE;
        end
      endcase
    end
endmodule

// File: tb/tb_pulse_meas.sv
// tb_pulse_meas: scoreboard bench for pulse_meas driving sample streams bit by bit.
module tb_pulse_meas;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, res_ready_i = 1'b1;
  logic [7:0] sample_i = '0;
  logic [10:0] pulse_num_i = '0;
  logic [15:0] timeout_us_i = '0;
  logic res_valid_o, res_sat_o, busy_o, done_o, timeout_o, overflow_o, glitch_o;
  logic [10:0] res_width_o, res_idx_o;
  logic [27:0] res_gap_o;
  typedef struct {int w; int g; int i; bit s;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0, done_cnt = 0, done_base = 0, wpos = 0;
  logic [7:0] wbuf = '0;
  logic line = 1'b0;
  pulse_meas dut (
    .clk(clk), .rst_n(rst_n), .sample_i(sample_i), .start_i(start_i),
    .pulse_num_i(pulse_num_i), .timeout_us_i(timeout_us_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_width_o(res_width_o), .res_gap_o(res_gap_o), .res_idx_o(res_idx_o), .res_sat_o(res_sat_o),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .overflow_o(overflow_o), .glitch_o(glitch_o)
  );
  always #4 clk = ~clk;
  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (res_valid_o && res_ready_i) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL result unexpected: got w=%0d g=%0d i=%0d s=%0d, none required", res_width_o, res_gap_o, res_idx_o, res_sat_o);
      end else begin
        e = q.pop_front();
        if ({res_width_o, res_gap_o, res_idx_o, res_sat_o} !== {11'(e.w), 28'(e.g), 11'(e.i), e.s}) begin
          bad++;
          $display("FAIL result: got w=%0d g=%0d i=%0d s=%0d, required w=%0d g=%0d i=%0d s=%0d",
                   res_width_o, res_gap_o, res_idx_o, res_sat_o, e.w, e.g, e.i, e.s);
        end
      end
    end
  end
  task automatic put(input logic v, input int n);
    for (int k = 0; k < n; k++) begin
      wbuf[wpos[2:0]] = v;
      line = v;
      wpos++;
      if (wpos == 8) begin
        sample_i = wbuf;
        wpos = 0;
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic idle(input int n);
    put(line, 8 * n);
  endtask
  task automatic push(input int w, input int g, input int i, input bit s);
    q.push_back('{w, g, i, s});
  endtask
  task automatic arm(input int num, input int to);
    pulse_num_i = 11'(num);
    timeout_us_i = 16'(to);
    done_base = done_cnt;
    start_i = 1'b1;
    idle(4);
    start_i = 1'b0;
  endtask
  task automatic finish_run;
    while (wpos != 0) put(line, 1);
    for (int i = 0; i < 60 && done_cnt == done_base; i++) idle(1);
    idle(2);
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({res_valid_o, busy_o, done_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset status: got valid/busy/done=%b, required 000", {res_valid_o, busy_o, done_o});
    end
    total++;
    if ({timeout_o, overflow_o, glitch_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset flags: got %b, required 000", {timeout_o, overflow_o, glitch_o});
    end
    total++;
    if ({res_width_o, res_gap_o, res_idx_o, res_sat_o} !== '0) begin
      bad++;
      $display("FAIL reset data: got w=%0d g=%0d i=%0d s=%0d, required 0", res_width_o, res_gap_o, res_idx_o, res_sat_o);
    end
    rst_n = 1'b1;
    idle(2);
  endtask
  task automatic test_basic;
    arm(3, 0);
    total++;
    if (busy_o !== 1'b1) begin
      bad++;
      $display("FAIL basic busy after arm: got %b, required 1", busy_o);
    end
    put(0, 3);
    push(5, 0, 0, 0);
    put(1, 5);
    put(0, 1000);
    push(8, 1000, 1, 0);
    put(1, 8);
    put(0, 1000);
    push(1027, 1000, 2, 0);
    put(1, 1027);
    put(0, 20);
    finish_run;
    total++;
    if (done_cnt !== done_base + 1) begin
      bad++;
      $display("FAIL basic done pulses: got %0d, required 1", done_cnt - done_base);
    end
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL basic busy after done: got %b, required 0", busy_o);
    end
  endtask
  task automatic test_rise_fall_word;
    arm(1, 0);
    push(4, 0, 0, 0);
    put(0, 2);
    put(1, 4);
    put(0, 2);
    total++;
    if (res_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL latency early valid: got %b, required 0", res_valid_o);
    end
    idle(1);
    total++;
    if (res_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL latency valid at N+2: got %b, required 1", res_valid_o);
    end
    finish_run;
    total++;
    if (done_cnt !== done_base + 1) begin
      bad++;
      $display("FAIL rise_fall done pulses: got %0d, required 1", done_cnt - done_base);
    end
  endtask
  task automatic test_fall_rise_word;
    arm(2, 0);
    put(0, 8);
    put(0, 4);
    push(5, 0, 0, 0);
    put(1, 5);
    put(0, 4);
    push(10, 4, 1, 0);
    put(1, 10);
    put(0, 9);
    finish_run;
    total++;
    if (done_cnt !== done_base + 1) begin
      bad++;
      $display("FAIL fall_rise done pulses: got %0d, required 1", done_cnt - done_base);
    end
  endtask
  task automatic test_line_high;
    put(1, 8);
    arm(1, 0);
    put(1, 5);
    put(0, 10);
    push(6, 0, 0, 0);
    put(1, 6);
    put(0, 10);
    finish_run;
    total++;
    if (done_cnt !== done_base + 1) begin
      bad++;
      $display("FAIL line_high done pulses: got %0d, required 1", done_cnt - done_base);
    end
  endtask
  task automatic test_saturate;
    arm(1, 0);
    put(0, 8);
    push(2047, 0, 0, 1);
    put(1, 2100);
    put(0, 10);
    finish_run;
    total++;
    if (done_cnt !== done_base + 1) begin
      bad++;
      $display("FAIL saturate done pulses: got %0d, required 1", done_cnt - done_base);
    end
  endtask
  task automatic test_overflow;
    arm(3, 0);
    res_ready_i = 1'b0;
    put(0, 8);
    push(3, 0, 0, 0);
    put(1, 3);
    put(0, 20);
    put(1, 4);
    put(0, 20);
    idle(2);
    total++;
    if (overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL overflow flag: got %b, required 1", overflow_o);
    end
    total++;
    if ({res_valid_o, res_idx_o, res_width_o} !== {1'b1, 11'd0, 11'd3}) begin
      bad++;
      $display("FAIL overflow held result: got valid=%b idx=%0d w=%0d, required valid=1 idx=0 w=3", res_valid_o, res_idx_o, res_width_o);
    end
    res_ready_i = 1'b1;
    idle(2);
    push(7, 52, 2, 0);
    put(1, 7);
    put(0, 20);
    finish_run;
    total++;
    if (done_cnt !== done_base + 1) begin
      bad++;
      $display("FAIL overflow done pulses: got %0d, required 1", done_cnt - done_base);
    end
  endtask
  task automatic test_glitch;
    logic [7:0] g;
    g = 8'b0101_0100;
    arm(1, 0);
    put(0, 8);
    for (int k = 0; k < 8; k++) put(g[k], 1);
    idle(2);
    total++;
    if ({glitch_o, res_valid_o} !== 2'b10) begin
      bad++;
      $display("FAIL glitch flag/valid: got %b, required 10", {glitch_o, res_valid_o});
    end
    push(3, 0, 0, 0);
    put(1, 3);
    put(0, 10);
    finish_run;
    total++;
    if (glitch_o !== 1'b1) begin
      bad++;
      $display("FAIL glitch sticky: got %b, required 1", glitch_o);
    end
  endtask
  task automatic test_timeout;
    int n;
    n = 0;
    pulse_num_i = 11'd0;
    timeout_us_i = 16'd2;
    done_base = done_cnt;
    start_i = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      idle(1);
      if (timeout_o === 1'b1) begin
        n = k;
        break;
      end
    end
    start_i = 1'b0;
    total++;
    if (n !== 253) begin
      bad++;
      $display("FAIL timeout cycles: got %0d, required 253", n);
    end
    total++;
    if ({glitch_o, overflow_o} !== 2'b00) begin
      bad++;
      $display("FAIL flags cleared by start: got %b, required 00", {glitch_o, overflow_o});
    end
    idle(4);
    total++;
    if (done_cnt !== done_base + 1) begin
      bad++;
      $display("FAIL timeout done pulses: got %0d, required 1", done_cnt - done_base);
    end
  endtask
  task automatic test_reset_mid;
    arm(2, 0);
    res_ready_i = 1'b0;
    put(0, 8);
    put(1, 3);
    put(0, 13);
    total++;
    if ({res_valid_o, busy_o} !== 2'b11) begin
      bad++;
      $display("FAIL reset_mid pending: got valid/busy=%b, required 11", {res_valid_o, busy_o});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({res_valid_o, busy_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset_mid cleared: got valid/busy=%b, required 00", {res_valid_o, busy_o});
    end
    res_ready_i = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_basic;
    test_rise_fall_word;
    test_fall_rise_word;
    test_line_high;
    test_saturate;
    test_overflow;
    test_glitch;
    test_timeout;
    test_reset_mid;
    total++;
    if (q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard leftover: got %0d pending, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_meas.md
# pulse_meas

Receive-side counterpart of the serialized pulse generator. Consumes the 8-bit parallel words produced by an 8:1 deserializer on the divided clock and measures each pulse at 1-sample resolution: width, preceding gap and index. Sample period is 1 ns at clk = 125 MHz. Per-pulse results go out on a valid/ready port. A measurement run is armed by a start edge and ends after a programmed pulse count or a timeout.

## Interface
- CYC_PER_US, 125, clk cycles per microsecond for the timeout base.
- TS_W, 32, width of the internal sample timestamp counter.
- clk  in  1  divided clock; one 8-sample word per cycle.
- rst_n  in  1  asynchronous, active-low reset.
- sample_i  in  8  deserialized word; bit 0 is the earliest sample, bit 7 the latest.
- start_i  in  1  a rising edge arms a run; ignored while busy.
- pulse_num_i  in  11  pulses to measure; 0 means run until timeout.
- timeout_us_i  in  16  idle limit in microseconds; 0 disables the timeout.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  consumer accepts the result.
- res_width_o  out  11  pulse width in samples; saturates at 2047.
- res_gap_o  out  28  samples from the previous fall to this rise; 0 for the first pulse; saturating.
- res_idx_o  out  11  pulse index within the run, 0-based.
- res_sat_o  out  1  width or gap saturated.
- busy_o  out  1  run in progress.
- done_o  out  1  one-cycle pulse at the end of a run.
- timeout_o, overflow_o, glitch_o  out  1 each  sticky error flags; cleared on the next accepted start.

## Operation
- Inputs are registered on entry. start_i goes through a 2-flop synchronizer followed by rising-edge detection. pulse_num_i and timeout_us_i are latched when the start edge is accepted.
- Edge detection: prev = bit 7 of the previous word. A rise at position p means b[p]=1 and b[p-1]=0, with b[-1]=prev. A fall is the inverse.
- Timestamp: ts = word_cnt·8 + p. word_cnt increments every cycle, wraps modulo 2^(TS_W-3), and is differenced modulo 2^TS_W.
- States:
  - IDLE: all counters cleared. Start edge goes to WAIT_LOW if the line is high, otherwise WAIT_RISE. This discards partial pulses.
  - WAIT_LOW: goes to WAIT_RISE on the first fall.
  - WAIT_RISE: on a rise, latch rise_ts, compute gap = rise_ts − last_fall_ts (0 if idx=0), then go to HIGH.
  - HIGH: on a fall, width = fall_ts − rise_ts and the result is emitted. If idx+1 == pulse_num_i (nonzero), go to DONE; otherwise go to WAIT_RISE.
  - DONE: done_o=1 for one cycle, then IDLE.
- A word holding both a rise and a fall is processed in bit order within the same cycle:
  - rise then fall: width < 8.
  - fall then rise: a result is emitted and a new pulse starts.
- More than 2 transitions in one word:
  - glitch_o is set.
  - Any pulse in progress is discarded with no result.
  - The FSM goes to WAIT_LOW if the word ends high, otherwise WAIT_RISE.
- Timeout:
  - The µs counter runs in every state except IDLE/DONE and clears on each fall.
  - When it reaches timeout_us_i (nonzero), timeout_o is set and the FSM goes to DONE.
  - No result is emitted for a pulse cut off by the timeout.
- Result port:
  - The result is held stable while res_valid_o && !res_ready_i.
  - If a new result completes while the port is stalled, that new result is dropped, overflow_o is set, and idx still increments.
- Saturation: width is capped at 2047 and gap at 2^28−1, with res_sat_o=1.

## Timing
- Reset values:
  - State IDLE.
  - res_valid_o, busy_o, done_o and all flags 0.
  - res_* data outputs 0.
- Latency: for a word at sample_i in cycle N that completes a pulse, res_valid_o rises at edge N+2.
- done_o asserts in the cycle after the final result register loads (N+3). A still-pending result stays valid past done.
- Start to armed: 3 cycles (synchronizer plus edge detect).
- busy_o is high from the state leaving IDLE until DONE exits.
- A start edge while busy is ignored.
- Asserting rst_n mid-run clears everything immediately. A pending result is lost.

## Structure
- Package pulse_meas_pkg holds:
  - the state enum, one-hot 5-bit: IDLE, WAIT_LOW, WAIT_RISE, HIGH, DONE;
  - WIDTH_MAX=2047 and GAP_MAX;
  - the result struct (width, gap, idx, sat).
- Sub-module pulse_edge_find: combinational plus one register stage. Input is the word and prev; outputs are rise/fall flags, their positions, order and the glitch flag.

## Test plan
- Reset, then start with pulse_num=3 and timeout=0. Drive three pulses of widths 5, 8 and 1027 samples with 1 µs gaps → results (5,0,0), (8,1000,1), (1027,1000,2) and one done_o.
- Rise at bit 2 and fall at bit 6 of the same word → width=4. In a separate run, fall at bit 1 then rise at bit 5 of one word → a result is emitted and the next gap is 4.
- Line held high at start → the partial pulse is ignored and the first result has idx 0 from the next full pulse.
- res_ready_i held 0 across two completed pulses → the first result is held, overflow_o=1, and the next accepted result carries idx=2.
- timeout=2 µs and no rise → timeout_o set after 250 cycles plus the arm latency, done_o pulses, no result.
- Word 0b0101_0100 with prev=0 → glitch_o=1, no result emitted.
